// File: rtl/axi_burst_reader.sv
// Turns a word-count DRAM read request into 4 KB-safe AXI4 INCR read bursts and streams the returned words out.
// Optional AXI_RD_BSWAP_EN: byte-swap each returned word into host order before it is written out.
module axi_burst_reader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  kick,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [31:0]           read_num,
    output logic [DATA_WIDTH-1:0] buf_dout,
    output logic                  buf_we,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, NEXT} state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           remaining;
    logic [8:0]            beats, beat_cnt;
    logic [12:0]           room;
    logic [31:0]           beats_c;
    logic                  beat, last_beat, ar_hs;
    logic [DATA_WIDTH-1:0] rdata_fmt;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, read_addr[1:0]};
    assign m_axi_arsize    = 3'b010;
    assign m_axi_arburst   = 2'b01;
    assign m_axi_rready    = (state == DATA);

`ifdef AXI_RD_BSWAP_EN
    assign rdata_fmt = {m_axi_rdata[7:0], m_axi_rdata[15:8], m_axi_rdata[23:16], m_axi_rdata[31:24]};
`else
    assign rdata_fmt = m_axi_rdata;
`endif

    // Burst length: bounded by what is left, MAX_BURST, and the words left before the next 4 KB page.
    always_comb begin
        room    = (13'd4096 - {1'b0, addr[11:0]}) >> 2;
        beats_c = 32'(MAX_BURST);
        if (32'(room) < beats_c)
            beats_c = 32'(room);
        if (remaining < beats_c)
            beats_c = remaining;
    end

    assign beat      = m_axi_rvalid & m_axi_rready;
    assign last_beat = (beat_cnt + 9'd1 == beats);
    assign ar_hs     = m_axi_arvalid & m_axi_arready;

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (kick && !busy && read_num != 32'd0) state_d = ADDR;
            ADDR: if (ar_hs) state_d = DATA;
            DATA: if (beat && (last_beat || m_axi_rlast)) state_d = NEXT;
            NEXT: state_d = (remaining == 32'(beats)) ? IDLE : ADDR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy          <= 1'b0;
            err           <= 1'b0;
            buf_we        <= 1'b0;
            buf_dout      <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            addr          <= '0;
            remaining     <= '0;
            beats         <= '0;
            beat_cnt      <= '0;
        end else begin
            buf_we <= 1'b0;
            case (state)
                IDLE: begin
                    // A zero-length request leaves busy up for one cycle; kicks are ignored meanwhile.
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (kick) begin
                        addr      <= {read_addr[ADDR_WIDTH-1:2], 2'b00};
                        remaining <= read_num;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                    end
                end
                ADDR: begin
                    if (!m_axi_arvalid) begin
                        m_axi_arvalid <= 1'b1;
                        m_axi_araddr  <= addr;
                        m_axi_arlen   <= 8'(beats_c - 32'd1);
                        beats         <= beats_c[8:0];
                        beat_cnt      <= '0;
                    end else if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                    end
                end
                DATA: begin
                    if (beat) begin
                        buf_dout <= rdata_fmt;
                        buf_we   <= 1'b1;
                        beat_cnt <= beat_cnt + 9'd1;
                        // rlast must coincide exactly with the expected final beat.
                        if (m_axi_rresp != 2'b00 || m_axi_rlast != last_beat)
                            err <= 1'b1;
                    end
                end
                NEXT: begin
                    addr      <= addr + (ADDR_WIDTH'(beats) << 2);
                    remaining <= remaining - 32'(beats);
                    if (remaining == 32'(beats))
                        busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_reader.sv
// Directed bench for axi_burst_reader: a hand-driven AXI slave and hand-computed expected bursts and words.
module tb_axi_burst_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        kick = 1'b0;
    logic        busy;
    logic [31:0] read_addr = '0;
    logic [31:0] read_num = '0;
    logic [31:0] buf_dout;
    logic        buf_we;
    logic        err;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] wq[$];

    always #5 clk = ~clk;

    axi_burst_reader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(16)) dut (
        .clk(clk), .rst(rst), .kick(kick), .busy(busy), .read_addr(read_addr), .read_num(read_num),
        .buf_dout(buf_dout), .buf_we(buf_we), .err(err),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always @(negedge clk) if (rst && buf_we) wq.push_back(buf_dout);

    function automatic logic [31:0] exp_w(input logic [31:0] d);
`ifdef AXI_RD_BSWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at a negedge.
    task automatic kick_req(input logic [31:0] a, input logic [31:0] n);
        wq.delete();
        kick = 1'b1; read_addr = a; read_num = n;
        @(negedge clk);
        kick = 1'b0;
    endtask

    task automatic expect_ar(input string tag, input logic [31:0] a, input logic [7:0] len);
        int i = 0;
        while (!m_axi_arvalid && i < 50) begin @(negedge clk); i++; end
        check({tag, "_arvalid"}, m_axi_arvalid, 1);
        check({tag, "_araddr"}, m_axi_araddr, a);
        check({tag, "_arlen"}, m_axi_arlen, len);
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        check({tag, "_ardrop"}, m_axi_arvalid, 0);
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
        m_axi_rvalid = 1'b1; m_axi_rdata = d; m_axi_rresp = resp; m_axi_rlast = last;
        check("rready", m_axi_rready, 1);
        @(negedge clk);
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
    endtask

    task automatic burst(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) beat(base + 32'(i), 2'b00, i == n - 1);
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (busy && i < 50) begin @(negedge clk); i++; end
        check({tag, "_busy_fall"}, busy, 0);
        @(negedge clk);
    endtask

    task automatic check_words(input string tag, input logic [31:0] base, input int n);
        check({tag, "_nwords"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++)
            check({tag, "_word"}, wq[i], exp_w(base + 32'(i)));
    endtask

    initial begin
        int cnt;
        // Reset state
        @(negedge clk);
        check("rst_ctl", {busy, buf_we, err, m_axi_arvalid, m_axi_rready}, 0);
        check("rst_araddr", m_axi_araddr, 0);
        check("rst_len_dout", {m_axi_arlen, buf_dout}, 0);
        check("ar_consts", {m_axi_arsize, m_axi_arburst}, {3'b010, 2'b01});
        rst = 1'b1;
        @(negedge clk);

        // 4 words at 0x1000, exact busy-fall timing
        kick_req(32'h1000, 4);
        check("t1_busy", busy, 1);
        expect_ar("t1", 32'h1000, 8'd3);
        burst(32'hA0, 4);
        check("t1_lastwe", {buf_we, busy}, 2'b11);
        @(negedge clk);
        check("t1_after", {buf_we, busy}, 2'b00);
        @(negedge clk);
        check_words("t1", 32'hA0, 4);
        check("t1_err", err, 0);

        // 40 words split by MAX_BURST
        kick_req(32'h0, 40);
        expect_ar("t2a", 32'h00, 8'd15);
        burst(32'd0, 16);
        expect_ar("t2b", 32'h40, 8'd15);
        burst(32'd16, 16);
        expect_ar("t2c", 32'h80, 8'd7);
        burst(32'd32, 8);
        wait_idle("t2");
        check_words("t2", 32'd0, 40);
        check("t2_err", err, 0);

        // 4 KB page split
        kick_req(32'hFF8, 8);
        expect_ar("t3a", 32'hFF8, 8'd1);
        burst(32'hC0, 2);
        expect_ar("t3b", 32'h1000, 8'd5);
        burst(32'hC2, 6);
        wait_idle("t3");
        check_words("t3", 32'hC0, 8);

        // arready stall with an ignored kick while busy
        kick_req(32'h200, 2);
        cnt = 0;
        while (!m_axi_arvalid && cnt < 50) begin @(negedge clk); cnt++; end
        for (int s = 0; s < 5; s++) begin
            check("t4_stall", {m_axi_arvalid, m_axi_araddr}, {1'b1, 32'h200});
            if (s == 1) begin kick = 1'b1; read_addr = 32'h3000; read_num = 9; end
            if (s == 2) kick = 1'b0;
            @(negedge clk);
        end
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        burst(32'h40, 2);
        wait_idle("t4");
        check_words("t4", 32'h40, 2);
        cnt = 0;
        for (int s = 0; s < 6; s++) begin
            if (m_axi_arvalid) cnt++;
            @(negedge clk);
        end
        check("t4_no_extra_ar", cnt, 0);

        // SLVERR on beat 2: error flagged, data still written
        kick_req(32'h100, 4);
        expect_ar("t5a", 32'h100, 8'd3);
        beat(32'h90, 2'b00, 1'b0);
        beat(32'h91, 2'b10, 1'b0);
        beat(32'h92, 2'b00, 1'b0);
        beat(32'h93, 2'b00, 1'b1);
        wait_idle("t5a");
        check("t5a_err", err, 1);
        check_words("t5a", 32'h90, 4);

        // Early rlast on beat 3 ends the burst; kick clears err first
        kick_req(32'h100, 4);
        check("t5b_err_clr", err, 0);
        expect_ar("t5b", 32'h100, 8'd3);
        beat(32'hB0, 2'b00, 1'b0);
        beat(32'hB1, 2'b00, 1'b0);
        beat(32'hB2, 2'b00, 1'b1);
        wait_idle("t5b");
        check("t5b_err", err, 1);
        check_words("t5b", 32'hB0, 3);

        // Zero-length request
        kick_req(32'h800, 0);
        check("t6_busy1", {busy, m_axi_arvalid, err}, 3'b100);
        @(negedge clk);
        check("t6_busy0", busy, 0);
        cnt = 0;
        for (int s = 0; s < 4; s++) begin
            if (m_axi_arvalid) cnt++;
            @(negedge clk);
        end
        check("t6_no_ar", cnt, 0);

        // Asynchronous reset mid-DATA, then a normal request
        kick_req(32'h500, 4);
        expect_ar("t7", 32'h500, 8'd3);
        beat(32'h70, 2'b00, 1'b0);
        beat(32'h71, 2'b00, 1'b0);
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h72;
        #2 rst = 1'b0;
        #1;
        check("t7_rst_ctl", {busy, buf_we, err, m_axi_arvalid, m_axi_rready}, 0);
        check("t7_rst_araddr", m_axi_araddr, 0);
        check("t7_rst_len_dout", {m_axi_arlen, buf_dout}, 0);
        m_axi_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        kick_req(32'h1000, 1);
        expect_ar("t8", 32'h1000, 8'd0);
        beat(32'h11223344, 2'b00, 1'b1);
        wait_idle("t8");
        check_words("t8", 32'h11223344, 1);
        check("t8_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
